// File: rtl/hazard_pkg.sv
// Shared types and default latencies for the ID-stage hazard controller.
// Producer latency is counted in cycles until the result is forwardable to ID.
package hazard_pkg;

    localparam int NUM_REGS_DEF = 32;
    localparam int MAX_LAT_DEF  = 4;
    localparam int LAT_W_DEF    = $clog2(MAX_LAT_DEF + 1);

    typedef logic [LAT_W_DEF-1:0] lat_t;

    typedef enum logic [2:0] {
        HZ_RESET,
        HZ_FREEZE,
        HZ_REDIRECT,
        HZ_STALL,
        HZ_RUN
    } hz_mode_e;

    localparam lat_t LAT_ALU  = lat_t'(0);
    localparam lat_t LAT_LOAD = lat_t'(1);
    localparam lat_t LAT_MUL  = lat_t'(2);
    localparam lat_t LAT_DIV  = lat_t'(MAX_LAT_DEF);

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register countdown of cycles until a pending result can be forwarded.
// Entry 0 is never loaded, so x0 can never appear busy.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int REG_AW   = $clog2(NUM_REGS),
    parameter int MAX_LAT  = MAX_LAT_DEF,
    parameter int LAT_W    = $clog2(MAX_LAT + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              advance,
    input  logic              load_en,
    input  logic [REG_AW-1:0] load_addr,
    input  logic [LAT_W-1:0]  load_lat,
    input  logic [REG_AW-1:0] rd_addr_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic              busy_a,
    output logic              busy_b
);

    logic [LAT_W-1:0] cnt [NUM_REGS];
    logic [LAT_W-1:0] load_val;

    always_comb begin
        load_val = load_lat;
        if (load_lat > LAT_W'(MAX_LAT)) begin
            load_val = LAT_W'(MAX_LAT);
        end
    end

    // A fresh load replaces the decrement of its entry, so the newest producer wins.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else if (advance) begin
            cnt[0] <= '0;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (load_en && (load_addr == REG_AW'(r))) begin
                    cnt[r] <= load_val;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - LAT_W'(1);
                end
            end
        end
    end

    always_comb begin
        busy_a = (rd_addr_a != '0) && (cnt[rd_addr_a] != '0);
        busy_b = (rd_addr_b != '0) && (cnt[rd_addr_b] != '0);
    end

endmodule

// File: rtl/hazard_unit.sv
// ID-stage hazard controller: picks one pipeline mode per cycle, drives stage
// enables/flushes, and counts hazard-stall cycles.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int REG_AW   = $clog2(NUM_REGS),
    parameter int MAX_LAT  = MAX_LAT_DEF,
    parameter int LAT_W    = $clog2(MAX_LAT + 1),
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] rs1_id,
    input  logic [REG_AW-1:0] rs2_id,
    input  logic              rs1_used,
    input  logic              rs2_used,
    input  logic [REG_AW-1:0] rd_id,
    input  logic              rd_we,
    input  logic [LAT_W-1:0]  issue_lat,
    input  logic              mem_stall,
    input  logic              redirect,
    input  logic              stall_cnt_clr,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_write,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              hazard,
    output logic [CNT_W-1:0]  stall_cnt
);

    hz_mode_e mode;
    logic     busy_rs1;
    logic     busy_rs2;
    logic     hazard_raw;
    logic     advance;
    logic     issue;
    logic     load_en;

    hazard_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .REG_AW   (REG_AW),
        .MAX_LAT  (MAX_LAT),
        .LAT_W    (LAT_W)
    ) u_scoreboard (
        .clk       (clk),
        .reset_n   (reset_n),
        .advance   (advance),
        .load_en   (load_en),
        .load_addr (rd_id),
        .load_lat  (issue_lat),
        .rd_addr_a (rs1_id),
        .rd_addr_b (rs2_id),
        .busy_a    (busy_rs1),
        .busy_b    (busy_rs2)
    );

    always_comb begin
        hazard_raw = id_valid && ((rs1_used && busy_rs1) || (rs2_used && busy_rs2));
        hazard     = reset_n && hazard_raw;
    end

    // A frozen EX keeps redirect asserted, so freeze must outrank redirect.
    always_comb begin
        mode = HZ_RUN;
        if (!reset_n) begin
            mode = HZ_RESET;
        end else if (mem_stall) begin
            mode = HZ_FREEZE;
        end else if (redirect) begin
            mode = HZ_REDIRECT;
        end else if (hazard_raw) begin
            mode = HZ_STALL;
        end
    end

    always_comb begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_write = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        case (mode)
            HZ_RESET: begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end
            HZ_FREEZE: begin
            end
            HZ_REDIRECT: begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
                id_ex_write = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end
            HZ_STALL: begin
                id_ex_write = 1'b1;
                id_ex_flush = 1'b1;
            end
            HZ_RUN: begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
                id_ex_write = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        advance = (mode != HZ_FREEZE) && (mode != HZ_RESET);
        issue   = id_valid && (mode == HZ_RUN);
        load_en = issue && rd_we && (rd_id != '0);
    end

    // Clear beats a same-cycle increment; the count saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (mode != HZ_FREEZE) begin
            if (stall_cnt_clr) begin
                stall_cnt <= '0;
            end else if ((mode == HZ_STALL) && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: each scenario is a table of per-cycle
// stimulus with the expected control vector and post-edge stall count.
module tb_hazard_unit;

    localparam logic [5:0] M_RESET  = 6'b000110;
    localparam logic [5:0] M_FREEZE = 6'b000000;
    localparam logic [5:0] M_REDIR  = 6'b111110;
    localparam logic [5:0] M_STALL  = 6'b001011;
    localparam logic [5:0] M_RUN    = 6'b111000;

    typedef struct {
        logic       rst_n;
        logic       valid;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic [2:0] lat;
        logic       ms;
        logic       redir;
        logic       clr;
        logic [5:0] mode;
        logic [3:0] sc;
    } stim_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       id_valid;
    logic [4:0] rs1_id;
    logic [4:0] rs2_id;
    logic       rs1_used;
    logic       rs2_used;
    logic [4:0] rd_id;
    logic       rd_we;
    logic [2:0] issue_lat;
    logic       mem_stall;
    logic       redirect;
    logic       stall_cnt_clr;
    logic       pc_write;
    logic       if_id_write;
    logic       id_ex_write;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       hazard;
    logic [3:0] stall_cnt;
    logic [5:0] obs;

    int    errors = 0;
    int    checks = 0;
    stim_t exp_q[$];

    assign obs = {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, hazard};

    always #5 clk = ~clk;

    hazard_unit #(
        .NUM_REGS (32),
        .MAX_LAT  (4),
        .CNT_W    (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .id_valid      (id_valid),
        .rs1_id        (rs1_id),
        .rs2_id        (rs2_id),
        .rs1_used      (rs1_used),
        .rs2_used      (rs2_used),
        .rd_id         (rd_id),
        .rd_we         (rd_we),
        .issue_lat     (issue_lat),
        .mem_stall     (mem_stall),
        .redirect      (redirect),
        .stall_cnt_clr (stall_cnt_clr),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .id_ex_write   (id_ex_write),
        .if_id_flush   (if_id_flush),
        .id_ex_flush   (id_ex_flush),
        .hazard        (hazard),
        .stall_cnt     (stall_cnt)
    );

    function automatic stim_t mk(input logic r, input logic v,
                                 input logic [4:0] a, input logic ua,
                                 input logic [4:0] b, input logic ub,
                                 input logic [4:0] d, input logic w, input logic [2:0] l,
                                 input logic m, input logic x, input logic c,
                                 input logic [5:0] md, input logic [3:0] s);
        stim_t t;
        t.rst_n = r;  t.valid = v;  t.rs1 = a;  t.u1 = ua;  t.rs2 = b;  t.u2 = ub;
        t.rd = d;     t.we = w;     t.lat = l;  t.ms = m;   t.redir = x; t.clr = c;
        t.mode = md;  t.sc = s;
        return t;
    endfunction

    // Drive one cycle of inputs and record what the DUT must produce for it.
    task automatic apply(input stim_t t);
        reset_n       = t.rst_n;
        id_valid      = t.valid;
        rs1_id        = t.rs1;
        rs1_used      = t.u1;
        rs2_id        = t.rs2;
        rs2_used      = t.u2;
        rd_id         = t.rd;
        rd_we         = t.we;
        issue_lat     = t.lat;
        mem_stall     = t.ms;
        redirect      = t.redir;
        stall_cnt_clr = t.clr;
        exp_q.push_back(t);
    endtask

    task automatic test_reset();
        stim_t t[$];
        stim_t e;
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, M_RESET, 0));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, M_RESET, 0));
        t.push_back(mk(1, 1, 0, 0, 0, 0, 5, 1, 3, 0, 0, 0, M_RUN,   0));
        t.push_back(mk(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, M_RESET, 0));
        t.push_back(mk(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, M_RESET, 0));
        t.push_back(mk(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, M_RUN,   0));
        foreach (t[i]) begin
            @(negedge clk);
            apply(t[i]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e.mode) begin
                errors++;
                $display("[TB] FAIL reset_ctrl step %0d: got %b want %b", i, obs, e.mode);
            end
            @(posedge clk);
            #1;
            checks++;
            if (stall_cnt !== e.sc) begin
                errors++;
                $display("[TB] FAIL reset_cnt step %0d: got %0d want %0d", i, stall_cnt, e.sc);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t t[$];
        stim_t e;
        t.push_back(mk(1, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 1, M_RUN,   0));
        t.push_back(mk(1, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, M_STALL, 1));
        t.push_back(mk(1, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, M_RUN,   1));
        foreach (t[i]) begin
            @(negedge clk);
            apply(t[i]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e.mode) begin
                errors++;
                $display("[TB] FAIL load_use_ctrl step %0d: got %b want %b", i, obs, e.mode);
            end
            @(posedge clk);
            #1;
            checks++;
            if (stall_cnt !== e.sc) begin
                errors++;
                $display("[TB] FAIL load_use_cnt step %0d: got %0d want %0d", i, stall_cnt, e.sc);
            end
        end
    endtask

    task automatic test_divide_freeze();
        stim_t t[$];
        stim_t e;
        t.push_back(mk(1, 1, 0, 0, 0, 0, 3, 1, 4, 0, 0, 1, M_RUN,             0));
        t.push_back(mk(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, M_STALL,           1));
        t.push_back(mk(1, 1, 3, 1, 0, 0, 0, 0, 0, 1, 0, 0, M_FREEZE | 6'b1,   1));
        t.push_back(mk(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, M_STALL,           2));
        t.push_back(mk(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, M_STALL,           3));
        t.push_back(mk(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, M_STALL,           4));
        t.push_back(mk(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, M_RUN,             4));
        foreach (t[i]) begin
            @(negedge clk);
            apply(t[i]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e.mode) begin
                errors++;
                $display("[TB] FAIL divide_ctrl step %0d: got %b want %b", i, obs, e.mode);
            end
            @(posedge clk);
            #1;
            checks++;
            if (stall_cnt !== e.sc) begin
                errors++;
                $display("[TB] FAIL divide_cnt step %0d: got %0d want %0d", i, stall_cnt, e.sc);
            end
        end
    endtask

    task automatic test_waw_x0();
        stim_t t[$];
        stim_t e;
        t.push_back(mk(1, 1, 0, 0, 0, 0, 9, 1, 4, 0, 0, 1, M_RUN, 0));
        t.push_back(mk(1, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, M_RUN, 0));
        t.push_back(mk(1, 1, 9, 1, 9, 1, 0, 0, 0, 0, 0, 0, M_RUN, 0));
        t.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, M_RUN, 0));
        t.push_back(mk(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, M_RUN, 0));
        foreach (t[i]) begin
            @(negedge clk);
            apply(t[i]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e.mode) begin
                errors++;
                $display("[TB] FAIL waw_x0_ctrl step %0d: got %b want %b", i, obs, e.mode);
            end
            @(posedge clk);
            #1;
            checks++;
            if (stall_cnt !== e.sc) begin
                errors++;
                $display("[TB] FAIL waw_x0_cnt step %0d: got %0d want %0d", i, stall_cnt, e.sc);
            end
        end
    endtask

    task automatic test_redirect_priority();
        stim_t t[$];
        stim_t e;
        t.push_back(mk(1, 1, 0, 0, 0, 0, 4, 1, 2, 0, 0, 1, M_RUN,           0));
        t.push_back(mk(1, 1, 4, 1, 0, 0, 6, 1, 4, 0, 1, 0, M_REDIR | 6'b1,  0));
        t.push_back(mk(1, 1, 4, 1, 0, 0, 6, 1, 4, 1, 1, 0, M_FREEZE | 6'b1, 0));
        t.push_back(mk(1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, M_STALL,         1));
        t.push_back(mk(1, 1, 4, 1, 6, 1, 0, 0, 0, 0, 0, 0, M_RUN,           1));
        foreach (t[i]) begin
            @(negedge clk);
            apply(t[i]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e.mode) begin
                errors++;
                $display("[TB] FAIL redirect_ctrl step %0d: got %b want %b", i, obs, e.mode);
            end
            @(posedge clk);
            #1;
            checks++;
            if (stall_cnt !== e.sc) begin
                errors++;
                $display("[TB] FAIL redirect_cnt step %0d: got %0d want %0d", i, stall_cnt, e.sc);
            end
        end
    endtask

    task automatic test_saturation_clear();
        stim_t t[$];
        stim_t e;
        int    k = 0;
        t.push_back(mk(1, 1, 0, 0, 0, 0, 10, 1, 4, 0, 0, 1, M_RUN, 0));
        // Each round: a reader of x10 that also rewrites x10 with latency 4.
        for (int round = 0; round < 5; round++) begin
            for (int j = 0; j < 4; j++) begin
                k++;
                t.push_back(mk(1, 1, 10, 1, 0, 0, 10, 1, 4, 0, 0, 0, M_STALL,
                               4'((k > 15) ? 15 : k)));
            end
            t.push_back(mk(1, 1, 10, 1, 0, 0, 10, 1, 4, 0, 0, 0, M_RUN,
                           4'((k > 15) ? 15 : k)));
        end
        t.push_back(mk(1, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 1, M_STALL, 0));
        t.push_back(mk(1, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, M_STALL, 1));
        for (int j = 0; j < 3; j++) begin
            t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, M_RUN, 1));
        end
        foreach (t[i]) begin
            @(negedge clk);
            apply(t[i]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e.mode) begin
                errors++;
                $display("[TB] FAIL saturate_ctrl step %0d: got %b want %b", i, obs, e.mode);
            end
            @(posedge clk);
            #1;
            checks++;
            if (stall_cnt !== e.sc) begin
                errors++;
                $display("[TB] FAIL saturate_cnt step %0d: got %0d want %0d", i, stall_cnt, e.sc);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n       = 1'b0;
        id_valid      = 1'b0;
        rs1_id        = '0;
        rs2_id        = '0;
        rs1_used      = 1'b0;
        rs2_used      = 1'b0;
        rd_id         = '0;
        rd_we         = 1'b0;
        issue_lat     = '0;
        mem_stall     = 1'b0;
        redirect      = 1'b0;
        stall_cnt_clr = 1'b0;
        test_reset();
        test_load_use();
        test_divide_freeze();
        test_waw_x0();
        test_redirect_priority();
        test_saturation_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
